// File: rtl/mode_sequencer_if.sv
// Button and mode-select bundle for the HOME shell mode controller.
// master: the sequencer (takes buttons, drives mode/enable/status).
// slave : the shell side (drives raw buttons, observes the selection).
interface mode_sequencer_if;
   logic [4:0] IN_BTN;
   logic [2:0] OUT_MODE;
   logic [7:0] OUT_ENABLE;
   logic [2:0] OUT_SEL_MODE;
   logic       OUT_BUSY;
   logic       OUT_CHANGED;

   modport master (
      input  IN_BTN,
      output OUT_MODE, OUT_ENABLE, OUT_SEL_MODE, OUT_BUSY, OUT_CHANGED
   );

   modport slave (
      output IN_BTN,
      input  OUT_MODE, OUT_ENABLE, OUT_SEL_MODE, OUT_BUSY, OUT_CHANGED
   );
endinterface

// File: rtl/mode_sequencer.sv
// HOME shell mode controller: debounces next/prev/enter buttons, browses the
// implemented M1..M7 modules and switches between them break-before-make,
// holding every module enable low for a guard window on each transition.
module mode_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned GUARD_CYCLES    = 4,
   parameter logic [7:0]  MODE_MASK       = 8'b0011_1111
) (
   input  logic                IN_CLK,
   input  logic                IN_RST,
   mode_sequencer_if.master    bus
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned GW  = $clog2(GUARD_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0]  GUARD_LOAD = GW'(GUARD_CYCLES);

   // Lowest implemented module above M0; 0 when none is implemented.
   function automatic logic [2:0] first_mode(input logic [7:0] mask);
      logic [2:0] m;
      m = '0;
      for (int unsigned i = 7; i >= 1; i--) begin
         if (mask[i]) m = 3'(i);
      end
      return m;
   endfunction

   localparam logic [2:0] SEL_RESET = first_mode(MODE_MASK);

   // Nearest implemented module in the chosen direction, cycling over 1..7.
   // Scanning from the farthest offset down lets the nearest match win.
   function automatic logic [2:0] step_sel(input logic [2:0] cur, input logic up);
      logic [2:0]  res;
      logic [2:0]  c3;
      int unsigned cand;
      res = cur;
      for (int unsigned k = 7; k >= 1; k--) begin
         if (up) cand = (32'(cur) + k - 1) % 7 + 1;
         else    cand = (32'(cur) + 6 - k + 7) % 7 + 1;
         c3 = 3'(cand);
         if (MODE_MASK[c3]) res = c3;
      end
      if (cur == '0) res = cur;
      return res;
   endfunction

   typedef enum logic [1:0] {BROWSE, GUARD_IN, RUN, GUARD_OUT} state_t;

   // Lane 0 = next (IN_BTN[1]), lane 1 = prev (IN_BTN[3]), lane 2 = enter (IN_BTN[4]).
   logic [2:0]     btn_raw;
   logic [2:0]     sync1, sync2, deb, press;
   logic [DBW-1:0] db_cnt [3];
   logic           unused_btn;

   assign btn_raw    = {bus.IN_BTN[4], bus.IN_BTN[3], bus.IN_BTN[1]};
   assign unused_btn = ^{bus.IN_BTN[2], bus.IN_BTN[0]};

   // Two-flop synchroniser for the raw button lines.
   always_ff @(posedge IN_CLK) begin
      if (IN_RST) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing
   // samples; the accepting edge also emits a one-cycle press on 0->1.
   always_ff @(posedge IN_CLK) begin
      if (IN_RST) begin
         deb   <= '0;
         press <= '0;
         for (int unsigned b = 0; b < 3; b++) db_cnt[b] <= '0;
      end else begin
         press <= '0;
         for (int unsigned b = 0; b < 3; b++) begin
            if (sync2[b] != deb[b]) begin
               if (db_cnt[b] == DB_LAST) begin
                  deb[b]    <= ~deb[b];
                  press[b]  <= ~deb[b];
                  db_cnt[b] <= '0;
               end else begin
                  db_cnt[b] <= db_cnt[b] + DBW'(1);
               end
            end else begin
               db_cnt[b] <= '0;
            end
         end
      end
   end

   logic ev_next, ev_prev, ev_enter;
   assign ev_next  = press[0];
   assign ev_prev  = press[1];
   assign ev_enter = press[2];

   state_t     state, state_n;
   logic [GW-1:0] guard_cnt, guard_cnt_n;
   logic [2:0] sel_q, sel_n;
   logic [2:0] mode_q, mode_n;
   logic       changed_q, changed_n;

   // Mode FSM state and output registers.
   always_ff @(posedge IN_CLK) begin
      if (IN_RST) begin
         state     <= BROWSE;
         guard_cnt <= '0;
         sel_q     <= SEL_RESET;
         mode_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         state     <= state_n;
         guard_cnt <= guard_cnt_n;
         sel_q     <= sel_n;
         mode_q    <= mode_n;
         changed_q <= changed_n;
      end
   end

   // Next-state: enter beats next beats prev; guards swallow every event.
   always_comb begin
      state_n     = state;
      guard_cnt_n = guard_cnt;
      sel_n       = sel_q;
      mode_n      = mode_q;
      changed_n   = 1'b0;
      case (state)
         BROWSE: begin
            if (ev_enter) begin
               if (sel_q != '0) begin
                  state_n     = GUARD_IN;
                  guard_cnt_n = GUARD_LOAD;
               end
            end else if (ev_next) begin
               sel_n = step_sel(sel_q, 1'b1);
            end else if (ev_prev) begin
               sel_n = step_sel(sel_q, 1'b0);
            end
         end
         GUARD_IN: begin
            guard_cnt_n = guard_cnt - GW'(1);
            if (guard_cnt_n == '0) begin
               state_n   = RUN;
               mode_n    = sel_q;
               changed_n = 1'b1;
            end
         end
         RUN: begin
            if (ev_enter) begin
               state_n     = GUARD_OUT;
               guard_cnt_n = GUARD_LOAD;
            end
         end
         GUARD_OUT: begin
            guard_cnt_n = guard_cnt - GW'(1);
            if (guard_cnt_n == '0) begin
               state_n   = BROWSE;
               mode_n    = '0;
               changed_n = 1'b1;
            end
         end
         default: state_n = BROWSE;
      endcase
   end

   logic busy;
   assign busy             = (state == GUARD_IN) || (state == GUARD_OUT);
   assign bus.OUT_BUSY     = busy;
   assign bus.OUT_MODE     = mode_q;
   assign bus.OUT_ENABLE   = busy ? '0 : (8'b1 << mode_q);
   assign bus.OUT_SEL_MODE = sel_q;
   assign bus.OUT_CHANGED  = changed_q;

endmodule
